// File: rtl/sched_pkg.sv
// Shared types and defaults for the two-layer convolution sequencer:
// state encoding, default PE masks, round-counter width and state-class helpers.
package sched_pkg;

    localparam int         ROUND_W        = 3;
    localparam int         DEF_NUM_PE     = 9;
    localparam int         DEF_NUM_ROUNDS = 5;
    localparam int         DEF_WD_CYCLES  = 1023;
    localparam logic [8:0] DEF_L1_MASK    = 9'h03F;
    localparam logic [8:0] DEF_L2_MASK    = 9'h1C0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEM     = 3'd1,
        ST_L1_GO   = 3'd2,
        ST_L1_WAIT = 3'd3,
        ST_L2_GO   = 3'd4,
        ST_L2_WAIT = 3'd5,
        ST_ADD     = 3'd6,
        ST_DONE    = 3'd7
    } seq_state_e;

    function automatic logic is_wait(input seq_state_e s);
        return (s == ST_L1_WAIT) || (s == ST_L2_WAIT);
    endfunction

    // States in which the sequencer is stalled on an external responder
    function automatic logic is_watched(input seq_state_e s);
        return (s == ST_MEM) || (s == ST_L1_WAIT) || (s == ST_L2_WAIT) || (s == ST_ADD);
    endfunction

endpackage

// File: rtl/wd_timer.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the LIMIT-th consecutive enabled cycle is reached.
module wd_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one two-layer convolution run: memory grant, per-round PE go/done
// handshakes for each layer, the final adder pass and the completion handshake.
module layer_sequencer
    import sched_pkg::*;
#(
    parameter int                NUM_PE     = DEF_NUM_PE,
    parameter logic [NUM_PE-1:0] L1_MASK    = NUM_PE'(DEF_L1_MASK),
    parameter logic [NUM_PE-1:0] L2_MASK    = NUM_PE'(DEF_L2_MASK),
    parameter int                NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int                WD_CYCLES  = DEF_WD_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    output logic               mem_go,
    input  logic               mem_ack,
    output logic [NUM_PE-1:0]  pe_go,
    input  logic [NUM_PE-1:0]  pe_done,
    output logic               add_go,
    input  logic               add_done,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [ROUND_W-1:0] round,
    output logic               layer,
    output logic               timeout_err
);

    seq_state_e         state;
    seq_state_e         next_state;
    logic [ROUND_W-1:0] round_cnt;
    logic [NUM_PE-1:0]  collect;
    logic [NUM_PE-1:0]  cur_mask;
    logic               timeout_flag;
    logic               layer_done;
    logic               last_round;
    logic               wd_clear;
    logic               wd_en;
    logic               wd_expired;

    // A pulse arriving in the completing cycle counts, so no extra cycle is lost
    assign cur_mask   = (state == ST_L2_WAIT) ? L2_MASK : L1_MASK;
    assign layer_done = (((collect | pe_done) & cur_mask) == cur_mask);
    assign last_round = (round_cnt == ROUND_W'(NUM_ROUNDS - 1));
    assign wd_en      = is_watched(state);
    assign wd_clear   = (next_state != state);

    wd_timer #(
        .LIMIT   (WD_CYCLES)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a watchdog expiry overrides any pending progress
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_valid) next_state = ST_MEM;
                else             next_state = ST_IDLE;
            end
            ST_MEM: begin
                if (wd_expired)   next_state = ST_IDLE;
                else if (mem_ack) next_state = ST_L1_GO;
                else              next_state = ST_MEM;
            end
            ST_L1_GO: next_state = ST_L1_WAIT;
            ST_L1_WAIT: begin
                if (wd_expired)      next_state = ST_IDLE;
                else if (!layer_done) next_state = ST_L1_WAIT;
                else if (last_round)  next_state = ST_L2_GO;
                else                  next_state = ST_L1_GO;
            end
            ST_L2_GO: next_state = ST_L2_WAIT;
            ST_L2_WAIT: begin
                if (wd_expired)      next_state = ST_IDLE;
                else if (!layer_done) next_state = ST_L2_WAIT;
                else if (last_round)  next_state = ST_ADD;
                else                  next_state = ST_L2_GO;
            end
            ST_ADD: begin
                if (wd_expired)    next_state = ST_IDLE;
                else if (add_done) next_state = ST_DONE;
                else               next_state = ST_ADD;
            end
            ST_DONE: begin
                if (done_ready) next_state = ST_IDLE;
                else            next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        start_ready = 1'b0;
        mem_go      = 1'b0;
        pe_go       = '0;
        add_go      = 1'b0;
        done_valid  = 1'b0;
        layer       = 1'b0;
        case (state)
            ST_IDLE:    start_ready = 1'b1;
            ST_MEM:     mem_go      = 1'b1;
            ST_L1_GO:   pe_go       = L1_MASK;
            ST_L1_WAIT: layer       = 1'b0;
            ST_L2_GO: begin
                pe_go = L2_MASK;
                layer = 1'b1;
            end
            ST_L2_WAIT: layer = 1'b1;
            ST_ADD: begin
                add_go = 1'b1;
                layer  = 1'b1;
            end
            ST_DONE: begin
                done_valid = 1'b1;
                layer      = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Round counter, PE completion collector and sticky watchdog flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_cnt    <= '0;
            collect      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (wd_expired) timeout_flag <= 1'b1;
            else            timeout_flag <= timeout_flag;

            if (next_state == ST_IDLE) begin
                round_cnt <= '0;
            end else if (is_wait(state) && layer_done) begin
                if (last_round) round_cnt <= '0;
                else            round_cnt <= round_cnt + ROUND_W'(1);
            end else begin
                round_cnt <= round_cnt;
            end

            if (state == ST_L1_GO || state == ST_L2_GO) begin
                collect <= '0;
            end else if (is_wait(state)) begin
                collect <= collect | (pe_done & cur_mask);
            end else begin
                collect <= collect;
            end
        end
    end

    assign round       = round_cnt;
    assign timeout_err = timeout_flag;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: scripted and randomized runs
// against a round-level timing model derived from the sequencing rules.
module tb_layer_sequencer;

    localparam int                NUM_PE     = 9;
    localparam int                NUM_ROUNDS = 5;
    localparam int                WD_CYCLES  = 1023;
    localparam logic [NUM_PE-1:0] L1_MASK    = 9'h03F;
    localparam logic [NUM_PE-1:0] L2_MASK    = 9'h1C0;
    localparam int                NOM_LAT    = 23;
    localparam logic [17:0]       RST_VEC    = {1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    logic              clk = 1'b0;
    logic              reset;
    logic              start_valid;
    logic              start_ready;
    logic              mem_go;
    logic              mem_ack;
    logic [NUM_PE-1:0] pe_go;
    logic [NUM_PE-1:0] pe_done;
    logic              add_go;
    logic              add_done;
    logic              done_valid;
    logic              done_ready;
    logic [2:0]        round;
    logic              layer;
    logic              timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    layer_sequencer #(
        .NUM_PE      (NUM_PE),
        .L1_MASK     (L1_MASK),
        .L2_MASK     (L2_MASK),
        .NUM_ROUNDS  (NUM_ROUNDS),
        .WD_CYCLES   (WD_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mem_go      (mem_go),
        .mem_ack     (mem_ack),
        .pe_go       (pe_go),
        .pe_done     (pe_done),
        .add_go      (add_go),
        .add_done    (add_done),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .round       (round),
        .layer       (layer),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    // One full run. mode 0: zero-delay responders, 1: random delays and noise,
    // 2: staggered finish in layer-1 round 2. The model predicts every go/ack cycle.
    task automatic run_flow(input int mode, output int done_cyc);
        int                c, dm, da, go_idx, exp_ev, add_cyc, maxd, comp;
        int                due [NUM_PE];
        logic [NUM_PE-1:0] act, want;
        logic [2:0]        exp_round;
        logic              exp_layer;
        bit                fin, stag;
        dm = (mode == 1) ? $urandom_range(0, 4) : 0;
        da = (mode == 1) ? $urandom_range(0, 4) : 0;
        done_cyc = -1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        c = 1; go_idx = 0; act = '0; fin = 1'b0; add_cyc = -1; comp = -1; stag = 1'b0;
        exp_ev = dm + 2;
        while (!fin && c < 300) begin
            mem_ack = (c >= 1 + dm) ? 1'b1 : 1'b0;
            pe_done = '0;
            if (pe_go !== '0) begin
                want      = (go_idx < NUM_ROUNDS) ? L1_MASK : L2_MASK;
                exp_round = 3'(go_idx % NUM_ROUNDS);
                exp_layer = (go_idx >= NUM_ROUNDS) ? 1'b1 : 1'b0;
                n_checks++;
                if (go_idx >= 2 * NUM_ROUNDS || pe_go !== want || c != exp_ev ||
                    round !== exp_round || layer !== exp_layer)
                    $display("FAIL pe_go_%0d: got go=%h cyc=%0d round=%0d layer=%b, want go=%h cyc=%0d round=%0d layer=%b",
                             go_idx, pe_go, c, round, layer, want, exp_ev, exp_round, exp_layer);
                else
                    n_pass++;
                maxd = 0;
                stag = (mode == 2 && go_idx == 2);
                for (int i = 0; i < NUM_PE; i++) begin
                    if (mode == 1)           due[i] = c + $urandom_range(1, 8);
                    else if (stag && i == 5) due[i] = c + 7;
                    else                     due[i] = c + 1;
                    if (want[i] && (due[i] - c) > maxd) maxd = due[i] - c;
                end
                comp   = c + maxd;
                exp_ev = comp + 1;
                act    = want;
                go_idx++;
                if (mode == 1) pe_done = NUM_PE'($urandom);
            end else if (act != '0) begin
                for (int i = 0; i < NUM_PE; i++) begin
                    if (act[i] && (c == due[i] ||
                        (c > due[i] && c <= comp &&
                         ((mode == 1 && $urandom_range(0, 2) == 0) || (stag && i == 0 && c == due[i] + 2)))))
                        pe_done[i] = 1'b1;
                    else if (!act[i] && mode == 1 && c <= comp)
                        pe_done[i] = ($urandom_range(0, 1) == 1);
                    else
                        pe_done[i] = 1'b0;
                end
                if (c == comp) act = '0;
            end
            if (add_go === 1'b1 && add_cyc < 0) begin
                add_cyc = c;
                n_checks++;
                if (c != exp_ev || go_idx != 2 * NUM_ROUNDS)
                    $display("FAIL add_go: got cyc=%0d after %0d pulses, want cyc=%0d after %0d",
                             c, go_idx, exp_ev, 2 * NUM_ROUNDS);
                else
                    n_pass++;
            end
            add_done = (add_cyc >= 0 && c >= add_cyc + da) ? 1'b1 : 1'b0;
            if (done_valid === 1'b1) begin
                n_checks++;
                if (add_cyc < 0 || c != add_cyc + da + 1)
                    $display("FAIL done_valid_rise: got cyc=%0d, want cyc=%0d", c, add_cyc + da + 1);
                else
                    n_pass++;
                done_cyc = c;
                fin = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        pe_done = '0;
        n_checks++;
        if (!fin || go_idx != 2 * NUM_ROUNDS)
            $display("FAIL run_complete: got finished=%b pulses=%0d, want finished=1 pulses=%0d",
                     fin, go_idx, 2 * NUM_ROUNDS);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if ({start_ready, mem_go, pe_go, add_go, done_valid, round, layer, timeout_err} !== RST_VEC)
            $display("FAIL reset_outputs: got %h want %h",
                     {start_ready, mem_go, pe_go, add_go, done_valid, round, layer, timeout_err}, RST_VEC);
        else
            n_pass++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int d;
        run_flow(0, d);
        n_checks++;
        if (d != NOM_LAT) $display("FAIL nominal_latency: got %0d want %0d", d, NOM_LAT);
        else              n_pass++;
        handshake();
        n_checks++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0)
            $display("FAIL nominal_return_idle: got ready=%b valid=%b want 1 0", start_ready, done_valid);
        else
            n_pass++;
    endtask

    task automatic test_staggered();
        int d;
        run_flow(2, d);
        handshake();
    endtask

    task automatic test_out_of_mask();
        logic bad;
        mem_ack = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        n_checks++;
        if (pe_go !== L1_MASK || round !== 3'd0) $display("FAIL oom_first_go: got %h/%0d want %h/0", pe_go, round, L1_MASK);
        else                                     n_pass++;
        tick();
        bad = 1'b0;
        pe_done = 9'h1C0;
        tick();
        if (pe_go !== '0 || round !== 3'd0) bad = 1'b1;
        pe_done = 9'h1DF;
        tick();
        if (pe_go !== '0 || round !== 3'd0) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL oom_no_advance: got go=%h round=%0d want go=0 round=0", pe_go, round);
        else     n_pass++;
        pe_done = 9'h020;
        tick();
        pe_done = '0;
        n_checks++;
        if (pe_go !== L1_MASK || round !== 3'd1) $display("FAIL oom_advance: got %h/%0d want %h/1", pe_go, round, L1_MASK);
        else                                     n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random();
        int d;
        for (int r = 0; r < 4; r++) begin
            run_flow(1, d);
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int   d;
        logic bad;
        run_flow(0, d);
        bad = 1'b0;
        start_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done_valid !== 1'b1 || start_ready !== 1'b0 || mem_go !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL bp_hold: got valid=%b ready=%b mem_go=%b want 1 0 0", done_valid, start_ready, mem_go);
        else     n_pass++;
        start_valid = 1'b0;
        handshake();
        n_checks++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0)
            $display("FAIL bp_release: got ready=%b valid=%b want 1 0", start_ready, done_valid);
        else
            n_pass++;
        tick();
        n_checks++;
        if (mem_go !== 1'b0) $display("FAIL bp_start_ignored: got mem_go=%b want 0", mem_go);
        else                 n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic              found, bad;
        logic [NUM_PE-1:0] prev;
        int                d;
        found = 1'b0; prev = '0;
        mem_ack = 1'b1; add_done = 1'b1; done_ready = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            pe_done = prev;
            prev = pe_go;
            if (pe_go !== '0 && layer === 1'b1 && round === 3'd3) found = 1'b1;
            else tick();
        end
        pe_done = '0;
        tick();
        n_checks++;
        if (!found) $display("FAIL rst_reach_l2_r3: got found=0 want 1");
        else        n_pass++;
        reset = 1'b1;
        #2;
        n_checks++;
        if ({start_ready, mem_go, pe_go, add_go, done_valid, round, layer, timeout_err} !== RST_VEC)
            $display("FAIL rst_async_outputs: got %h want %h",
                     {start_ready, mem_go, pe_go, add_go, done_valid, round, layer, timeout_err}, RST_VEC);
        else
            n_pass++;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (pe_go !== '0 || add_go !== 1'b0 || done_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL rst_quiet: got activity during reset, want none");
        else     n_pass++;
        reset = 1'b0; mem_ack = 1'b0; add_done = 1'b0;
        run_flow(0, d);
        handshake();
    endtask

    task automatic test_watchdog();
        int d;
        mem_ack = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 2; c <= WD_CYCLES; c++) tick();
        n_checks++;
        if (timeout_err !== 1'b0 || mem_go !== 1'b1)
            $display("FAIL wd_before_limit: got err=%b mem_go=%b want 0 1", timeout_err, mem_go);
        else
            n_pass++;
        tick();
        n_checks++;
        if (timeout_err !== 1'b1 || start_ready !== 1'b1 || mem_go !== 1'b0)
            $display("FAIL wd_expired: got err=%b ready=%b mem_go=%b want 1 1 0", timeout_err, start_ready, mem_go);
        else
            n_pass++;
        run_flow(0, d);
        n_checks++;
        if (d != NOM_LAT || timeout_err !== 1'b1)
            $display("FAIL wd_rerun: got lat=%0d err=%b want %0d 1", d, timeout_err, NOM_LAT);
        else
            n_pass++;
        handshake();
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; mem_ack = 1'b0; pe_done = '0;
        add_done = 1'b0; done_ready = 1'b0;
        test_reset();
        test_nominal();
        test_staggered();
        test_out_of_mask();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_PE, default 9: number of PE go/done lanes.
REQ-002 Parameter L1_MASK, default 9'h03F: PEs used by conv layer 1.
REQ-003 Parameter L2_MASK, default 9'h1C0: PEs used by conv layer 2.
REQ-004 Parameter NUM_ROUNDS, default 5: rounds per layer (output rows).
REQ-005 Parameter WD_CYCLES, default 1023: watchdog limit in wait states.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 start_valid  in  1  run request.
REQ-009 start_ready  out  1  sequencer idle and able to accept a run request.
REQ-010 mem_go  out  1  memory block cleared to serve ifmap/filter traffic.
REQ-011 mem_ack  in  1  memory block ready.
REQ-012 pe_go  out  NUM_PE  per-PE round-start pulse.
REQ-013 pe_done  in  NUM_PE  per-PE round-complete pulse.
REQ-014 add_go  out  1  final accumulator/adder enable.
REQ-015 add_done  in  1  adder finished writing results.
REQ-016 done_valid  out  1  run complete.
REQ-017 done_ready  in  1  consumer accepts completion.
REQ-018 round  out  3  current round index, 0..NUM_ROUNDS-1.
REQ-019 layer  out  1  0 = layer 1, 1 = layer 2.
REQ-020 timeout_err  out  1  sticky watchdog flag.

Function
REQ-021 The FSM SHALL have states IDLE, MEM, L1_GO, L1_WAIT, L2_GO, L2_WAIT, ADD and DONE; all outputs are Moore-decoded from registers.
REQ-022 IDLE: start_ready=1; start_valid=1 at an edge -> MEM; start_valid in any other state is ignored.
REQ-023 MEM: mem_go=1 (level); mem_ack=1 -> L1_GO.
REQ-024 Lx_GO: lasts exactly one cycle; pe_go=Lx_MASK, all other bits 0; clears the collect register; -> Lx_WAIT; pe_done is ignored in this state.
REQ-025 Lx_WAIT: collect |= pe_done & Lx_MASK; bits outside the mask and repeated pulses are ignored.
REQ-026 When (collect | pe_done) & Lx_MASK == Lx_MASK in Lx_WAIT: if round < NUM_ROUNDS-1, round++ and -> Lx_GO; else round <= 0 and -> L2_GO (from L1) or ADD (from L2).
REQ-027 layer=1 in L2_GO, L2_WAIT, ADD and DONE; layer=0 otherwise.
REQ-028 ADD: add_go=1 (level); add_done=1 -> DONE.
REQ-029 DONE: done_valid=1 until done_ready=1 -> IDLE; done_valid and done_ready high in the same cycle complete the handshake.
REQ-030 Latency with zero-delay responders (acks in the first cycle they are legal): done_valid SHALL rise 23 cycles after the start-accept edge.
REQ-031 Watchdog: a cycle counter clears on every state change and counts in MEM, Lx_WAIT and ADD; reaching WD_CYCLES sets timeout_err and -> IDLE.
REQ-032 timeout_err SHALL stay 1 until reset; a new start is still accepted while it is set.

Reset
REQ-033 While reset=1: state=IDLE, round=0, layer=0, collect=0, watchdog=0, timeout_err=0, start_ready=1, all other outputs 0.
REQ-034 Reset asserted mid-run SHALL abort immediately, with no further pe_go, add_go or done_valid.

Structure
REQ-035 The state enum, the default masks and the round-counter width SHALL live in a shared package sched_pkg.
REQ-036 The watchdog SHALL be a sub-module wd_timer with ports clk, reset, clear, en and expired.

Verification
REQ-037 Nominal run: start, immediate mem_ack, all pe_done one cycle after each pe_go, add_done immediate -> 10 pe_go pulses, 5 of 9'h03F then 5 of 9'h1C0; done_valid 23 cycles after accept.
REQ-038 Staggered done: in round 2 PEs 0-4 finish at cycle +1 and PE5 at +7, with a duplicate PE0 pulse -> next pe_go exactly 1 cycle after the PE5 pulse; the duplicate has no effect.
REQ-039 Out-of-mask pe_done: pe_done=9'h1C0 during L1_WAIT -> no round advance.
REQ-040 Watchdog: withhold mem_ack for 1023 cycles -> timeout_err=1 and state IDLE; the next start runs normally with timeout_err still 1.
REQ-041 Reset mid-run: reset asserted during L2_WAIT round 3 -> outputs take reset values asynchronously; a following start begins again at layer 0, round 0.
REQ-042 Done back-pressure: done_ready held 0 for 5 cycles -> done_valid stays 1 and start_valid is ignored; IDLE is entered the cycle after done_ready=1.
